sa_seq_ctrl: RTL and testbench
==============================

Name: sa_seq_ctrl

Overview:
- Sequencer for an N x N weight-stationary systolic array of PE cells.
- Per job it clears the array, optionally loads weights row by row from a weight buffer, then streams M activation vectors with row/column-skewed enables.
- Raises per-column output-valid strobes for the bottom-row PSUM outputs, and signals completion.
- Sits between the host/job FIFO and the PE grid; activation data skew lines and memories are external.

Parameters:
- N, 4, array dimension: rows = columns = N, N >= 2.
- MW, 8, width of the activation count M_LEN and of A_ADDR.
- NW, $clog2(N), width of W_ADDR.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  job request; sampled only in IDLE.
- W_KEEP  in  1  sampled with START; 1 skips the weight clear and weight load.
- M_LEN  in  MW  sampled with START; number of activation vectors.
- ABORT  in  1  synchronous job cancel.
- BUSY  out  1  job in progress.
- DONE  out  1  one-cycle completion pulse.
- CLR_DP  out  1  datapath clear to all PEs.
- CLR_W  out  1  weight clear to all PEs.
- W_RD_EN  out  1  weight buffer read strobe.
- W_ADDR  out  NW  weight buffer row address.
- W_LOAD  out  N  one-hot per-row weight load; 1-cycle buffer latency is absorbed here.
- A_RD_EN  out  1  activation buffer read strobe.
- A_ADDR  out  MW  activation vector index.
- EN_LEFT  out  N  per-row left-edge enable (ENLeft of column 0).
- EN_TOP  out  N  per-column top-edge enable (ENTop of row 0).
- OUT_VALID  out  N  per-column: bottom-row PSUM_OUT holds a valid result.

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0. Reset mid-job abandons the job with no DONE.
- Outputs are registered. Cycle 0 is the cycle START=1 is sampled in IDLE.
- States: IDLE -> CLR -> WLOAD (skipped if W_KEEP) -> STREAM -> DRAIN -> FIN -> IDLE.
- BUSY is 1 from cycle 1 until the cycle before DONE. It is 0 in the DONE cycle.
- START while not in IDLE is ignored. M_LEN and W_KEEP are latched at cycle 0.
- CLR (cycle 1): CLR_DP=1; CLR_W=~W_KEEP.
- WLOAD (cycles 2..N+1): W_RD_EN=1, W_ADDR=i for i=0..N-1. W_LOAD[i]=1 exactly at cycle 3+i, so W_LOAD is never multi-hot.
- Stream origin S0: N+2 if W_KEEP=0, else 2. The last W_LOAD overlaps S0, which is legal.
- A_RD_EN=1 with A_ADDR=k at cycle S0+k, for k=0..M-1.
- EN_LEFT[r]=1 for cycles S0+1+r .. S0+M+r.
- EN_TOP[c]=1 for cycles S0+1+c .. S0+M+c.
- Consequence: PE(r,c) sees both enables for vector k at S0+1+k+r+c.
- OUT_VALID[c]=1 for cycles S0+1+N+c .. S0+N+c+M.
- DONE=1 at cycle S0+2N+M, the cycle after the last OUT_VALID[N-1]. Return to IDLE on the next cycle.
- M_LEN=0: no A_RD_EN, EN_* or OUT_VALID. DONE is at S0 and the weights are still loaded.
- Timing: one free-running stream counter T of width MW+$clog2(N)+2 counts from S0. All windows are compared against T; no per-output shift chains. M_LEN = 2^MW-1 must not overflow T.
- ABORT (any non-IDLE state): next cycle CLR_DP=1, and every other output except BUSY is 0. The following cycle the block is in IDLE with BUSY=0 and no DONE. ABORT in IDLE is a no-op.
- ABORT and START in the same IDLE cycle: START wins.

Test Plan:
- N=4, START with W_KEEP=0, M_LEN=3:
  - CLR_DP and CLR_W at cycle 1.
  - W_ADDR 0..3 at cycles 2..5; W_LOAD 0001,0010,0100,1000 at cycles 3..6.
  - A_ADDR 0..2 at cycles 6..8.
  - EN_LEFT[0] at 7..9, EN_LEFT[3] at 10..12; EN_TOP same windows.
  - OUT_VALID[0] at 11..13, OUT_VALID[3] at 14..16; DONE at 17.
- Same job with W_KEEP=1: CLR_W=0, no W_RD_EN/W_LOAD, A_ADDR 0..2 at cycles 2..4, DONE at 13.
- M_LEN=0, W_KEEP=0: weights load as above; DONE at cycle 6; EN_LEFT, EN_TOP and OUT_VALID stay 0.
- ABORT at cycle 9 of the first scenario:
  - Cycle 10: CLR_DP=1, EN_*=0, OUT_VALID=0, DONE never pulses.
  - IDLE at cycle 11; a new START at 11 runs normally.
- START held high through a job: exactly one job runs. Back-to-back START at the cycle after DONE: the second job's cycle 0 is that cycle.
- RSTN low at cycle 8 of a job: all outputs 0 asynchronously; after release, START=1 begins a job at the next clock edge.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: job sequencer for an N x N weight-stationary systolic array.
// Per job: clear the array, optionally load weights row by row, stream M
// activation vectors with row/column-skewed edge enables, flag bottom-row
// PSUM validity per column, then pulse DONE. Every output is registered and
// is computed from the state/counters that will hold in the following cycle.
module sa_seq_ctrl #(
  parameter int N  = 4,
  parameter int MW = 8,
  parameter int NW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic          W_KEEP,
  input  logic [MW-1:0] M_LEN,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic          CLR_DP,
  output logic          CLR_W,
  output logic          W_RD_EN,
  output logic [NW-1:0] W_ADDR,
  output logic [N-1:0]  W_LOAD,
  output logic          A_RD_EN,
  output logic [MW-1:0] A_ADDR,
  output logic [N-1:0]  EN_LEFT,
  output logic [N-1:0]  EN_TOP,
  output logic [N-1:0]  OUT_VALID
);

  // Stream counter is wide enough to reach 2N + (2^MW - 1) without wrapping.
  localparam int TW = MW + $clog2(N) + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_WLOAD  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5,
    S_ABRT   = 3'd6
  } state_t;

  state_t          state_q, state_d, nstate_s;
  logic            keep_q, keep_d;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [TW-1:0]   m_ext_s, t_end_s, t_inc_s;
  logic            stream_s;

  logic            busy_q, busy_d, done_q, done_d;
  logic            clr_dp_q, clr_dp_d, clr_w_q, clr_w_d;
  logic            w_rd_en_q, w_rd_en_d;
  logic [NW-1:0]   w_addr_q, w_addr_d;
  logic [N-1:0]    w_load_q, w_load_d;
  logic            a_rd_en_q, a_rd_en_d;
  logic [MW-1:0]   a_addr_q, a_addr_d;
  logic [N-1:0]    en_left_q, en_left_d, en_top_q, en_top_d;
  logic [N-1:0]    out_valid_q, out_valid_d;

  assign m_ext_s = TW'(m_q);
  assign t_end_s = TW'(2 * N) + m_ext_s;
  assign t_inc_s = t_q + TW'(1);

  // Next state and counters; ABORT outside IDLE overrides the normal sequence.
  always_comb begin
    nstate_s = state_q;
    keep_d   = keep_q;
    m_d      = m_q;
    wcnt_d   = wcnt_q;
    t_d      = t_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          nstate_s = S_CLR;
          keep_d   = W_KEEP;
          m_d      = M_LEN;
          wcnt_d   = '0;
          t_d      = '0;
        end else begin
          nstate_s = S_IDLE;
        end
      end
      S_CLR: begin
        if (keep_q) begin
          t_d      = '0;
          nstate_s = (m_q == '0) ? S_FIN : S_STREAM;
        end else begin
          wcnt_d   = '0;
          nstate_s = S_WLOAD;
        end
      end
      S_WLOAD: begin
        if (wcnt_q == NW'(N - 1)) begin
          t_d      = '0;
          nstate_s = (m_q == '0) ? S_FIN : S_STREAM;
        end else begin
          wcnt_d   = wcnt_q + NW'(1);
          nstate_s = S_WLOAD;
        end
      end
      S_STREAM: begin
        t_d = t_inc_s;
        if (t_inc_s == t_end_s) begin
          nstate_s = S_FIN;
        end else if (t_inc_s >= m_ext_s) begin
          nstate_s = S_DRAIN;
        end else begin
          nstate_s = S_STREAM;
        end
      end
      S_DRAIN: begin
        t_d = t_inc_s;
        if (t_inc_s == t_end_s) begin
          nstate_s = S_FIN;
        end else begin
          nstate_s = S_DRAIN;
        end
      end
      S_FIN:   nstate_s = S_IDLE;
      S_ABRT:  nstate_s = S_IDLE;
      default: nstate_s = S_IDLE;
    endcase
    state_d = (ABORT && (state_q != S_IDLE)) ? S_ABRT : nstate_s;
  end

  // Output values for the coming cycle, decoded from next state and counters.
  always_comb begin
    stream_s    = (state_d == S_STREAM) || (state_d == S_DRAIN);
    busy_d      = (state_d == S_CLR) || (state_d == S_WLOAD) || stream_s || (state_d == S_ABRT);
    done_d      = (state_d == S_FIN);
    clr_dp_d    = (state_d == S_CLR) || (state_d == S_ABRT);
    clr_w_d     = (state_d == S_CLR) && !keep_d;
    w_rd_en_d   = (state_d == S_WLOAD);
    w_addr_d    = w_rd_en_d ? wcnt_d : '0;
    // Weight load trails the buffer read by one cycle (buffer latency).
    if (w_rd_en_q && (state_d != S_ABRT)) begin
      w_load_d = {{(N-1){1'b0}}, 1'b1} << w_addr_q;
    end else begin
      w_load_d = '0;
    end
    a_rd_en_d   = stream_s && (t_d < m_ext_s);
    a_addr_d    = a_rd_en_d ? t_d[MW-1:0] : '0;
    en_left_d   = '0;
    out_valid_d = '0;
    for (int r = 0; r < N; r++) begin
      en_left_d[r]   = stream_s && (t_d >= TW'(r + 1)) && (t_d <= m_ext_s + TW'(r));
      out_valid_d[r] = stream_s && (t_d >= TW'(N + 1 + r)) && (t_d <= m_ext_s + TW'(N + r));
    end
    // Row and column edges share the same skew, so one window serves both.
    en_top_d    = en_left_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      keep_q      <= 1'b0;
      m_q         <= '0;
      wcnt_q      <= '0;
      t_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_dp_q    <= 1'b0;
      clr_w_q     <= 1'b0;
      w_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      w_load_q    <= '0;
      a_rd_en_q   <= 1'b0;
      a_addr_q    <= '0;
      en_left_q   <= '0;
      en_top_q    <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      keep_q      <= keep_d;
      m_q         <= m_d;
      wcnt_q      <= wcnt_d;
      t_q         <= t_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clr_dp_q    <= clr_dp_d;
      clr_w_q     <= clr_w_d;
      w_rd_en_q   <= w_rd_en_d;
      w_addr_q    <= w_addr_d;
      w_load_q    <= w_load_d;
      a_rd_en_q   <= a_rd_en_d;
      a_addr_q    <= a_addr_d;
      en_left_q   <= en_left_d;
      en_top_q    <= en_top_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CLR_DP    = clr_dp_q;
  assign CLR_W     = clr_w_q;
  assign W_RD_EN   = w_rd_en_q;
  assign W_ADDR    = w_addr_q;
  assign W_LOAD    = w_load_q;
  assign A_RD_EN   = a_rd_en_q;
  assign A_ADDR    = a_addr_q;
  assign EN_LEFT   = en_left_q;
  assign EN_TOP    = en_top_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: a per-cycle model derives every output from the
// job's start cycle, W_KEEP, M and an optional abort cycle, and a single
// compare process checks the DUT against it on every falling edge.
module tb_sa_seq_ctrl;

  localparam int N  = 4;
  localparam int MW = 8;
  localparam int NW = 2;

  logic          CLK = 1'b0;
  logic          RSTN, START, W_KEEP, ABORT;
  logic [MW-1:0] M_LEN;
  logic          BUSY, DONE, CLR_DP, CLR_W, W_RD_EN, A_RD_EN;
  logic [NW-1:0] W_ADDR;
  logic [N-1:0]  W_LOAD, EN_LEFT, EN_TOP, OUT_VALID;
  logic [MW-1:0] A_ADDR;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr_dp;
    logic          clr_w;
    logic          w_rd_en;
    logic [NW-1:0] w_addr;
    logic [N-1:0]  w_load;
    logic          a_rd_en;
    logic [MW-1:0] a_addr;
    logic [N-1:0]  en_left;
    logic [N-1:0]  en_top;
    logic [N-1:0]  out_valid;
  } out_t;

  out_t dut_v, exp_v;
  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   job_valid = 1'b0;
  bit   job_keep = 1'b0;
  int   job_t0 = 0, job_m = 0, job_abort = -1;

  sa_seq_ctrl #(.N(N), .MW(MW), .NW(NW)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .W_KEEP(W_KEEP), .M_LEN(M_LEN),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .CLR_DP(CLR_DP), .CLR_W(CLR_W),
    .W_RD_EN(W_RD_EN), .W_ADDR(W_ADDR), .W_LOAD(W_LOAD), .A_RD_EN(A_RD_EN),
    .A_ADDR(A_ADDR), .EN_LEFT(EN_LEFT), .EN_TOP(EN_TOP), .OUT_VALID(OUT_VALID)
  );

  assign dut_v = {BUSY, DONE, CLR_DP, CLR_W, W_RD_EN, W_ADDR, W_LOAD, A_RD_EN,
                  A_ADDR, EN_LEFT, EN_TOP, OUT_VALID};

  always #5 CLK = ~CLK;

  // Cycle index: number of rising edges so far.
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected outputs in job cycle c (cycle 0 = START sampled).
  function automatic out_t model(int c, bit valid, bit keep, int m, int abort_c);
    out_t e;
    int   s0, dc;
    e = '0;
    if (!valid || c < 1) return e;
    s0 = keep ? 2 : N + 2;
    dc = (m == 0) ? s0 : s0 + 2 * N + m;
    if (abort_c >= 0 && abort_c < dc && c > abort_c) begin
      if (c == abort_c + 1) begin
        e.clr_dp = 1'b1;
        e.busy   = 1'b1;
      end
      return e;
    end
    if (c > dc) return e;
    e.busy   = (c < dc);
    e.done   = (c == dc);
    e.clr_dp = (c == 1);
    e.clr_w  = (c == 1) && !keep;
    if (!keep && c >= 2 && c <= N + 1) begin
      e.w_rd_en = 1'b1;
      e.w_addr  = NW'(c - 2);
    end
    if (!keep && c >= 3 && c <= N + 2) e.w_load[c - 3] = 1'b1;
    if (c >= s0 && c < s0 + m) begin
      e.a_rd_en = 1'b1;
      e.a_addr  = MW'(c - s0);
    end
    for (int r = 0; r < N; r++) begin
      e.en_left[r]   = (c >= s0 + 1 + r) && (c <= s0 + m + r);
      e.en_top[r]    = e.en_left[r];
      e.out_valid[r] = (c >= s0 + 1 + N + r) && (c <= s0 + N + r + m);
    end
    return e;
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      exp_v = model(cyc - job_t0, job_valid, job_keep, job_m, job_abort);
      checks = checks + 1;
      if (dut_v !== exp_v) begin
        failures = failures + 1;
        $display("FAIL cycle_cmp cyc=%0d jobc=%0d got=%h exp=%h",
                 cyc, cyc - job_t0, dut_v, exp_v);
      end
    end
  end

  task automatic pin(string nm, int got, int want);
    checks = checks + 1;
    if (got != want) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic start_job(bit keep, int m);
    START     = 1'b1;
    W_KEEP    = keep;
    M_LEN     = MW'(m);
    job_valid = 1'b1;
    job_keep  = keep;
    job_m     = m;
    job_t0    = cyc;
    job_abort = -1;
  endtask

  initial begin
    out_t p;
    RSTN = 1'b0; START = 1'b0; W_KEEP = 1'b0; ABORT = 1'b0; M_LEN = '0;

    // Hand-computed anchors for the model itself.
    p = model(17, 1'b1, 1'b0, 3, -1); pin("m_done17", int'(p.done), 1);
    p = model(16, 1'b1, 1'b0, 3, -1); pin("m_busy16", int'(p.busy), 1);
    p = model(14, 1'b1, 1'b0, 3, -1); pin("m_ov14", int'(p.out_valid), 14);
    p = model(9, 1'b1, 1'b0, 3, -1);  pin("m_enl9", int'(p.en_left), 7);
    p = model(6, 1'b1, 1'b0, 3, -1);  pin("m_wload6", int'(p.w_load), 8);
    p = model(8, 1'b1, 1'b0, 3, -1);  pin("m_aaddr8", int'(p.a_addr), 2);
    p = model(13, 1'b1, 1'b1, 3, -1); pin("m_keep_done13", int'(p.done), 1);
    p = model(6, 1'b1, 1'b0, 0, -1);  pin("m_m0_done6", int'(p.done), 1);
    p = model(10, 1'b1, 1'b0, 3, 9);  pin("m_abort10", int'(p.clr_dp), 1);

    step(3);
    pin("reset_outs", int'(dut_v != '0), 0);
    RSTN   = 1'b1;
    chk_en = 1'b1;
    step(2);

    // Full job with weight load, M=3.
    start_job(1'b0, 3); step(1); START = 1'b0; step(20);
    // Weights kept, M=3.
    start_job(1'b1, 3); step(1); START = 1'b0; step(16);
    // M=0: weights load, no streaming.
    start_job(1'b0, 0); step(1); START = 1'b0; step(10);
    // ABORT in job cycle 9, then a new job in cycle 11.
    start_job(1'b0, 3); step(1); START = 1'b0; step(8);
    ABORT = 1'b1; job_abort = 9; step(1);
    ABORT = 1'b0; step(1);
    start_job(1'b1, 2); step(1); START = 1'b0; step(16);
    // START held through the whole job: one job only.
    start_job(1'b1, 2); step(12); START = 1'b0; step(6);
    // Back-to-back: second START in the cycle after DONE.
    start_job(1'b1, 1); step(1); START = 1'b0; step(11);
    start_job(1'b0, 2); step(1); START = 1'b0; step(20);
    // ABORT alone in IDLE does nothing; ABORT with START in IDLE starts a job.
    ABORT = 1'b1; step(2);
    start_job(1'b1, 1); step(1); START = 1'b0; ABORT = 1'b0; step(14);
    // Asynchronous reset in job cycle 8, then a job right after release.
    start_job(1'b0, 3); step(1); START = 1'b0; step(7);
    RSTN = 1'b0; job_valid = 1'b0; #1;
    pin("async_reset", int'(dut_v != '0), 0);
    step(2);
    RSTN = 1'b1;
    start_job(1'b1, 2); step(1); START = 1'b0; step(14);
    // Maximum M: the stream counter must not wrap.
    start_job(1'b1, 255); step(1); START = 1'b0; step(270);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
